// File: rtl/gcd_bank.sv
// gcd_bank: bank of modulo-MOD accumulator entries. In SETUP each entry can be
// incremented by data_in. A 'next' request computes the GCD of all entries one
// subtract/swap step per cycle, and the result readout then shows each entry
// divided by that GCD.
module gcd_bank #(
  parameter  int WIDTH   = 4,
  parameter  int ENTRIES = 2,
  parameter  int MOD     = 10,
  localparam int SEL_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] select,
  input  logic             add,
  input  logic             next,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    SETUP  = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] entry_q [ENTRIES];
  logic [WIDTH-1:0] entry_d [ENTRIES];
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             add_prev_q, add_prev_d;
  logic             next_prev_q, next_prev_d;

  logic             add_pulse_s;
  logic             next_pulse_s;
  logic             sel_valid_s;
  logic [WIDTH-1:0] sel_entry_s;
  logic [WIDTH-1:0] nxt_entry_s;
  logic [WIDTH-1:0] upd_val_s;
  logic [WIDTH-1:0] post_entry_s;
  logic [WIDTH:0]   sum_s;
  logic [SEL_W-1:0] idx_inc_s;

  // Entry scaled by the GCD; a zero GCD (all entries zero) leaves it unscaled.
  function automatic logic [WIDTH-1:0] scaled(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] g);
    if (g == {WIDTH{1'b0}}) begin
      return x;
    end else begin
      return x / g;
    end
  endfunction

  // Edge detection, entry lookup for select and idx+1, and the modular sum.
  always_comb begin
    add_pulse_s  = add & ~add_prev_q;
    next_pulse_s = next & ~next_prev_q;
    sel_valid_s  = (32'(select) < 32'(ENTRIES));
    idx_inc_s    = idx_q + SEL_W'(1);
    sel_entry_s  = {WIDTH{1'b0}};
    nxt_entry_s  = {WIDTH{1'b0}};
    for (int i = 0; i < ENTRIES; i++) begin
      sel_entry_s = (select == SEL_W'(i)) ? entry_q[i] : sel_entry_s;
      nxt_entry_s = (idx_inc_s == SEL_W'(i)) ? entry_q[i] : nxt_entry_s;
    end
    // Sum carried at WIDTH+1 bits so data_in near 2^WIDTH cannot wrap early.
    sum_s        = {1'b0, sel_entry_s} + {1'b0, data_in};
    upd_val_s    = WIDTH'(sum_s % (WIDTH+1)'(MOD));
    post_entry_s = (add_pulse_s && sel_valid_s) ? upd_val_s : sel_entry_s;
  end

  // Next-state logic for the mode FSM, the entries and the GCD datapath.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    a_d         = a_q;
    b_d         = b_q;
    gcd_d       = gcd_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    data_out_d  = data_out_q;
    add_prev_d  = add;
    next_prev_d = next;

    case (state_q)
      SETUP: begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (add_pulse_s && sel_valid_s && (select == SEL_W'(i))) begin
            entry_d[i] = upd_val_s;
          end else begin
            entry_d[i] = entry_q[i];
          end
        end
        data_out_d = post_entry_s;
        // A simultaneous add is already folded into entry_d, so CALC sees it.
        if (next_pulse_s) begin
          state_d = CALC;
          busy_d  = 1'b1;
          a_d     = entry_d[0];
          b_d     = entry_d[1];
          idx_d   = SEL_W'(1);
        end else begin
          state_d = SETUP;
        end
      end
      CALC: begin
        if (next_pulse_s) begin
          state_d    = SETUP;
          busy_d     = 1'b0;
          data_out_d = sel_entry_s;
        end else if (b_q == {WIDTH{1'b0}}) begin
          // a is the GCD of entries 0..idx; fold in the next entry or finish.
          if (idx_q == SEL_W'(ENTRIES - 1)) begin
            gcd_d   = a_q;
            state_d = RESULT;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_inc_s;
            b_d   = nxt_entry_s;
          end
        end else if (a_q >= b_q) begin
          a_d = a_q - b_q;
        end else begin
          a_d = b_q;
          b_d = a_q;
        end
      end
      RESULT: begin
        if (next_pulse_s) begin
          state_d    = SETUP;
          data_out_d = sel_entry_s;
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = SETUP;
        busy_d  = 1'b0;
      end
    endcase

    // Result readout uses gcd_d so the first RESULT cycle is already scaled.
    if (state_d == RESULT) begin
      data_out_d = scaled(sel_entry_s, gcd_d);
    end else begin
      data_out_d = data_out_d;
    end
    if (!sel_valid_s) begin
      data_out_d = {WIDTH{1'b0}};
    end else begin
      data_out_d = data_out_d;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SETUP;
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= {WIDTH{1'b0}};
      end
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      gcd_q       <= {WIDTH{1'b0}};
      idx_q       <= {SEL_W{1'b0}};
      busy_q      <= 1'b0;
      data_out_q  <= {WIDTH{1'b0}};
      add_prev_q  <= 1'b0;
      next_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= entry_d[i];
      end
      a_q         <= a_d;
      b_q         <= b_d;
      gcd_q       <= gcd_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      data_out_q  <= data_out_d;
      add_prev_q  <= add_prev_d;
      next_prev_q <= next_prev_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_gcd_bank.sv
// Directed bench for gcd_bank: a default instance driven from a vector table,
// plus hand sequences on 2-, 3- and 4-entry instances for the corner cases.
module tb_gcd_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       add = 1'b0;
  logic       next = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] din = 4'd0;

  logic [3:0] out2, out3, out4;
  logic       busy2, busy3, busy4;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [1:0] sel;
    logic       add;
    logic       nxt;
    logic [3:0] din;
    logic [3:0] exp_out;
    logic       exp_busy;
  } vec_t;

  vec_t vq[$];

  gcd_bank dut2 (
    .clk(clk), .rst_n(rst_n), .select(sel[0]), .add(add), .next(next),
    .data_in(din), .data_out(out2), .busy(busy2)
  );

  gcd_bank #(.WIDTH(4), .ENTRIES(3), .MOD(10)) dut3 (
    .clk(clk), .rst_n(rst_n), .select(sel), .add(add), .next(next),
    .data_in(din), .data_out(out3), .busy(busy3)
  );

  gcd_bank #(.WIDTH(4), .ENTRIES(4), .MOD(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .select(sel), .add(add), .next(next),
    .data_in(din), .data_out(out4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] s, input logic a, input logic n,
                         input logic [3:0] d, input logic [3:0] eo, input logic eb);
    vec_t v;
    v.sel = s; v.add = a; v.nxt = n; v.din = d; v.exp_out = eo; v.exp_busy = eb;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; add = 1'b0; next = 1'b0; sel = 2'd0; din = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load2(input logic [3:0] v0, input logic [3:0] v1);
    sel = 2'd0; din = v0; add = 1'b1; tick();
    add = 1'b0; tick();
    sel = 2'd1; din = v1; add = 1'b1; tick();
    add = 1'b0; tick();
  endtask

  task automatic wait_idle2(input int limit);
    int n = 0;
    while (busy2 && n < limit) begin
      tick();
      n++;
    end
    check("busy2_timeout", 32'(busy2), 32'd0);
  endtask

  task automatic wait_idle4(input int limit);
    int n = 0;
    while (busy4 && n < limit) begin
      tick();
      n++;
    end
    check("busy4_timeout", 32'(busy4), 32'd0);
  endtask

  initial begin
    logic [3:0] vals4 [4];
    logic [3:0] exps4 [4];

    // Vector table for the default instance (MOD=10): sel, add, next, din, out, busy
    add_vec(2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    add_vec(2'd0, 1'b1, 1'b0, 4'd7, 4'd7, 1'b0);
    add_vec(2'd0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0);
    add_vec(2'd0, 1'b1, 1'b0, 4'd5, 4'd2, 1'b0);   // 7+5 mod 10
    add_vec(2'd0, 1'b1, 1'b0, 4'd5, 4'd2, 1'b0);   // held: no second add
    add_vec(2'd0, 1'b1, 1'b0, 4'd5, 4'd2, 1'b0);
    add_vec(2'd0, 1'b0, 1'b0, 4'd5, 4'd2, 1'b0);
    add_vec(2'd1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0);   // held 5 cycles -> 3
    add_vec(2'd1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0);
    add_vec(2'd1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0);
    add_vec(2'd1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0);
    add_vec(2'd1, 1'b1, 1'b0, 4'd3, 4'd3, 1'b0);
    add_vec(2'd1, 1'b0, 1'b0, 4'd3, 4'd3, 1'b0);
    add_vec(2'd0, 1'b1, 1'b0, 4'd4, 4'd6, 1'b0);   // 2+4
    add_vec(2'd0, 1'b0, 1'b0, 4'd4, 4'd6, 1'b0);
    add_vec(2'd1, 1'b1, 1'b0, 4'd6, 4'd9, 1'b0);   // 3+6
    add_vec(2'd1, 1'b0, 1'b0, 4'd6, 4'd9, 1'b0);
    add_vec(2'd1, 1'b0, 1'b1, 4'd0, 4'd9, 1'b1);   // enter CALC on (6,9)
    add_vec(2'd1, 1'b0, 1'b1, 4'd0, 4'd9, 1'b1);   // swap -> (9,6)
    add_vec(2'd1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1);   // (3,6)
    add_vec(2'd1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1);   // (6,3)
    add_vec(2'd1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1);   // (3,3)
    add_vec(2'd1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1);   // (0,3)
    add_vec(2'd1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1);   // (3,0)
    add_vec(2'd1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0);   // gcd 3, 9/3
    add_vec(2'd0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0);   // 6/3
    add_vec(2'd1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0);
    add_vec(2'd0, 1'b1, 1'b0, 4'd5, 4'd2, 1'b0);   // add in RESULT discarded
    add_vec(2'd0, 1'b0, 1'b0, 4'd5, 4'd2, 1'b0);
    add_vec(2'd0, 1'b0, 1'b1, 4'd0, 4'd6, 1'b0);   // back to SETUP, raw entry
    add_vec(2'd1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0);
    add_vec(2'd1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0);   // 9+1 wraps to 0

    // Outputs while held in reset
    @(negedge clk);
    check("reset_out", 32'(out2), 32'd0);
    check("reset_busy", 32'(busy2), 32'd0);
    do_reset();

    foreach (vq[k]) begin
      sel = vq[k].sel; add = vq[k].add; next = vq[k].nxt; din = vq[k].din;
      tick();
      check($sformatf("vec%0d_out", k), 32'(out2), 32'(vq[k].exp_out));
      check($sformatf("vec%0d_busy", k), 32'(busy2), 32'(vq[k].exp_busy));
    end
    add = 1'b0; next = 1'b0;

    // All-zero entries: gcd 0, readout unscaled
    do_reset();
    next = 1'b1; tick(); next = 1'b0;
    wait_idle2(44);
    sel = 2'd0; tick(); check("zero_sel0", 32'(out2), 32'd0);
    sel = 2'd1; tick(); check("zero_sel1", 32'(out2), 32'd0);

    // Add and next on the same cycle: CALC sees entries (0,4) -> gcd 4
    do_reset();
    sel = 2'd1; din = 4'd4; add = 1'b1; next = 1'b1; tick();
    check("addnext_out", 32'(out2), 32'd4);
    check("addnext_busy", 32'(busy2), 32'd1);
    add = 1'b0; next = 1'b0;
    wait_idle2(44);
    sel = 2'd1; tick(); check("addnext_res1", 32'(out2), 32'd1);
    sel = 2'd0; tick(); check("addnext_res0", 32'(out2), 32'd0);

    // Abort mid-CALC with a second next pulse
    do_reset();
    load2(4'd6, 4'd9);
    next = 1'b1; tick();
    check("abort_busy_on", 32'(busy2), 32'd1);
    next = 1'b0; tick(); tick();
    next = 1'b1; tick();
    check("abort_busy_off", 32'(busy2), 32'd0);
    check("abort_out", 32'(out2), 32'd9);
    next = 1'b0; tick(); tick(); tick();
    check("abort_stays_idle", 32'(busy2), 32'd0);
    check("abort_hold_out", 32'(out2), 32'd9);
    sel = 2'd0; din = 4'd1; add = 1'b1; tick();
    check("abort_add_works", 32'(out2), 32'd7);
    add = 1'b0;

    // Asynchronous reset in the middle of CALC
    do_reset();
    load2(4'd6, 4'd9);
    next = 1'b1; tick(); next = 1'b0; tick();
    check("midcalc_busy", 32'(busy2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy2), 32'd0);
    check("async_rst_out", 32'(out2), 32'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    sel = 2'd1; tick();
    check("post_rst_entry1", 32'(out2), 32'd0);
    sel = 2'd0; din = 4'd1; add = 1'b1; tick();
    check("post_rst_add", 32'(out2), 32'd1);
    add = 1'b0; tick();

    // Four entries, MOD 16: 12,8,0,4 -> gcd 4 -> 3,2,0,1
    vals4[0] = 4'd12; vals4[1] = 4'd8; vals4[2] = 4'd0; vals4[3] = 4'd4;
    exps4[0] = 4'd3;  exps4[1] = 4'd2; exps4[2] = 4'd0; exps4[3] = 4'd1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); din = vals4[k]; add = 1'b1; tick();
      check($sformatf("e4_load%0d", k), 32'(out4), 32'(vals4[k]));
      add = 1'b0; tick();
    end
    next = 1'b1; tick(); next = 1'b0;
    check("e4_busy", 32'(busy4), 32'd1);
    wait_idle4(136);
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); tick();
      check($sformatf("e4_res%0d", k), 32'(out4), 32'(exps4[k]));
    end

    // Three entries: select 3 is out of range
    do_reset();
    sel = 2'd0; din = 4'd5; add = 1'b1; tick();
    check("e3_load0", 32'(out3), 32'd5);
    add = 1'b0; tick();
    sel = 2'd3; din = 4'd2; add = 1'b1; tick();
    check("e3_bad_sel_add", 32'(out3), 32'd0);
    add = 1'b0; tick();
    check("e3_bad_sel_hold", 32'(out3), 32'd0);
    sel = 2'd0; tick(); check("e3_entry0_kept", 32'(out3), 32'd5);
    sel = 2'd1; tick(); check("e3_entry1_zero", 32'(out3), 32'd0);
    sel = 2'd2; tick(); check("e3_entry2_zero", 32'(out3), 32'd0);
    check("e3_busy", 32'(busy3), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gcd_bank.md
GCD_BANK -- requirements
Module: gcd_bank

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bit width of each stored digit, data_in and data_out.
REQ-002 Parameter ENTRIES, default 2, SHALL set the number of stored entries; legal range is 2..16.
REQ-003 Parameter MOD, default 10, SHALL set the additive modulus; legal range is 2..2^WIDTH.
REQ-004 Derived SEL_W = clog2(ENTRIES) SHALL set the select width.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 select  input  SEL_W  SHALL give the entry index addressed by add and data_out.
REQ-008 add  input  1  SHALL be the level request whose rising edge adds data_in to the selected entry.
REQ-009 next  input  1  SHALL be the level request whose rising edge advances the mode.
REQ-010 data_in  input  WIDTH  SHALL be the addend.
REQ-011 data_out  output  WIDTH  SHALL be the registered result.
REQ-012 busy  output  1  SHALL be the registered flag, high only while the GCD is being computed.

Function
REQ-013 add and next SHALL each be edge-detected against a registered previous sample (reset 0); a pulse is one cycle long per 0->1 transition, however long the input is held.
REQ-014 The FSM SHALL have states SETUP, CALC and RESULT; the reset state is SETUP.
REQ-015 SETUP, add pulse: entry[select] <= (entry[select] + data_in) mod MOD, with the sum formed at WIDTH+1 bits so it cannot overflow.
REQ-016 SETUP: data_out SHALL be the post-update value of entry[select], registered, with 1-cycle latency.
REQ-017 select >= ENTRIES SHALL ignore add and SHALL drive data_out to 0, in all states.
REQ-018 SETUP, next pulse -> CALC; on the same edge: busy <= 1, a <= entry[0], b <= entry[1], idx <= 1.
REQ-019 CALC SHALL perform one step per cycle:
  - b == 0: a holds the pair GCD; if idx == ENTRIES-1, then gcd <= a, go to RESULT, busy <= 0; otherwise idx++, b <= entry[idx+1].
  - else if a >= b: a <= a - b.
  - else: swap a and b.
REQ-020 gcd(0,x) SHALL be x; if all entries are 0, gcd SHALL be 0.
REQ-021 CALC SHALL terminate within ENTRIES*(2*MOD+2) cycles.
REQ-022 Entries SHALL be frozen in CALC and RESULT; add pulses there are discarded, not queued.
REQ-023 data_out SHALL hold its last value during CALC.
REQ-024 RESULT: data_out SHALL be registered entry[select] / gcd (integer divide), or entry[select] when gcd == 0; it tracks select changes with 1-cycle latency.
REQ-025 RESULT, next pulse -> SETUP; data_out <= entry[select] on the same edge.
REQ-026 CALC, next pulse SHALL abort: go to SETUP, busy <= 0, gcd unchanged, data_out <= entry[select].
REQ-027 An add and a next pulse in the same SETUP cycle SHALL apply the add and then transition; CALC uses the updated entry.

Reset
REQ-028 rst_n low SHALL immediately clear all entries, a, b, idx, gcd, the edge-detect registers and data_out to 0, set busy to 0 and set the state to SETUP, in any state including mid-CALC.
REQ-029 The first cycle after rst_n releases SHALL not produce an add or next pulse unless the input rises after release.

Verification (defaults unless noted)
REQ-030 entry0=7, select=0, add pulse with data_in=5 -> entry0=2, data_out=2 one cycle later.
REQ-031 add held high 5 cycles with data_in=3 from 0 -> entry=3 (single add).
REQ-032 entries 6,9, next pulse -> busy high, then RESULT with gcd=3; select=0 -> 2, select=1 -> 3; next pulse -> data_out=6 or 9.
REQ-033 entries 0,0, next pulse -> RESULT with gcd=0, data_out=0 for both selects.
REQ-034 ENTRIES=4, MOD=16: entries 12,8,0,4 -> gcd=4; data_out 3,2,0,1 for selects 0..3.
REQ-035 rst_n low mid-CALC (entries 6,9) -> busy=0, data_out=0, entries 0, state SETUP; the next add with data_in=1 gives 1.
